// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first borrow chain, one bit per clock.
// Optional signed overflow flag Ovf via SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d, bnext;
  logic             last, accept;
  logic             unused_lsb;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb, b_msb;
`endif

  assign d       = a_sr[0] ^ b_sr[0] ^ borrow;
  assign bnext   = (~a_sr[0] & b_sr[0]) |
                   (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign res_nxt = {d, res_sr[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign accept  = start && (state == IDLE || state == DONE);

  // result LSB only ever shifts out
  assign unused_lsb = res_sr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   if (last) nxt = DONE;
      DONE:    nxt = start ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      borrow <= bnext;
      cnt    <= last ? '0 : cnt + CW'(1);
      // outputs only move on the final bit
      if (last) begin
        Diff <= res_nxt;
        Bout <= bnext;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        Ovf  <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
      end
    end
  end

endmodule
